// File: rtl/bubble_sort_ctrl_pkg.sv
// Shared types and constants for the sequential odd-even transposition sorter.
package bubble_sort_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SORT  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int MODE_ASC  = 0;
  localparam int MODE_DESC = 1;

endpackage

// File: rtl/bubble_sort_ctrl_cas.sv
// One odd-even transposition pass: compare-swap of disjoint neighbour pairs.
module sort_cas_pass
  import bubble_sort_pkg::*;
#(
  parameter int DW   = 8,
  parameter int NUM  = 8,
  parameter int MODE = MODE_ASC
) (
  input  logic [NUM-1:0][DW-1:0] data_i,
  input  logic                   odd_i,
  output logic [NUM-1:0][DW-1:0] data_o,
  output logic                   any_swap_o
);

  always_comb begin
    // NOTE: combinational outputs get a default first so no path leaves them unassigned (no latch).
    data_o     = data_i;
    any_swap_o = 1'b0;
    for (int i = 0; i < NUM - 1; i++) begin
      if (odd_i == i[0]) begin
        // Strict compare keeps equal keys in place, so the sort is stable.
        if ((MODE == MODE_DESC) ? (data_i[i] < data_i[i+1])
                                : (data_i[i] > data_i[i+1])) begin
          data_o[i]   = data_i[i+1];
          data_o[i+1] = data_i[i];
          any_swap_o  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/bubble_sort_ctrl.sv
// Sequential sort engine: load NUM words, sort in place one pass per clock, stream out.
// Optional BUBBLE_SORT_CTRL_EARLY_EXIT_EN ends SORT after two consecutive swap-free passes.
module bubble_sort_ctrl
  import bubble_sort_pkg::*;
#(
  parameter int DW   = 8,
  parameter int NUM  = 8,
  parameter int MODE = MODE_ASC
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic          m_last,
  output logic          busy
);

  localparam int             CW   = $clog2(NUM + 1);
  localparam int             IW   = $clog2(NUM);
  localparam logic [CW-1:0]  LAST = CW'(NUM - 1);

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [NUM-1:0][DW-1:0] buf_q, buf_d, pass_data;
  logic                   any_swap;
  logic [IW-1:0]          idx;

  assign idx = cnt_q[IW-1:0];

  sort_cas_pass #(
    .DW   (DW),
    .NUM  (NUM),
    .MODE (MODE)
  ) u_pass (
    .data_i     (buf_q),
    .odd_i      (cnt_q[0]),
    .data_o     (pass_data),
    .any_swap_o (any_swap)
  );

`ifdef BUBBLE_SORT_CTRL_EARLY_EXIT_EN
  // Set when the previous pass made no swap; two quiet passes in a row mean sorted.
  logic quiet_q, quiet_d;
`else
  logic unused_any_swap;
  assign unused_any_swap = any_swap;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
`ifdef BUBBLE_SORT_CTRL_EARLY_EXIT_EN
    quiet_d = quiet_q;
`endif
    case (state_q)
      LOAD: begin
`ifdef BUBBLE_SORT_CTRL_EARLY_EXIT_EN
        quiet_d = 1'b0;
`endif
        if (s_valid && s_ready) begin
          buf_d[idx] = s_data;
          if (cnt_q == LAST) begin
            state_d = SORT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      SORT: begin
        buf_d = pass_data;
`ifdef BUBBLE_SORT_CTRL_EARLY_EXIT_EN
        quiet_d = !any_swap;
        if (cnt_q == LAST || (quiet_q && !any_swap)) begin
`else
        if (cnt_q == LAST) begin
`endif
          state_d = DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DRAIN: begin
        if (m_valid && m_ready) begin
          if (cnt_q == LAST) begin
            state_d = LOAD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = LOAD;
        cnt_d   = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments; the storage array is reset too so a
  // discarded batch can never leak out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOAD;
      cnt_q   <= '0;
      buf_q   <= '0;
`ifdef BUBBLE_SORT_CTRL_EARLY_EXIT_EN
      quiet_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
`ifdef BUBBLE_SORT_CTRL_EARLY_EXIT_EN
      quiet_q <= quiet_d;
`endif
    end
  end

  assign s_ready = (state_q == LOAD);
  assign m_valid = (state_q == DRAIN);
  assign busy    = (state_q != LOAD);
  assign m_data  = m_valid ? buf_q[idx] : '0;
  assign m_last  = m_valid && (cnt_q == LAST);

endmodule

// File: tb/tb_bubble_sort_ctrl.sv
// Directed bench: one ascending and one descending engine, hand-computed sorted outputs.
module tb_bubble_sort_ctrl;

  typedef logic [7:0] vec_t [8];

  logic       clk;
  logic       rst_n;
  logic [1:0] s_valid, s_ready, m_valid, m_ready, m_last, busy;
  logic [7:0] s_data [2];
  logic [7:0] m_data [2];

  int n_tests = 0;
  int n_fail  = 0;

  bubble_sort_ctrl #(.DW(8), .NUM(8), .MODE(0)) dut_asc (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_valid (s_valid[0]),
    .s_ready (s_ready[0]),
    .s_data  (s_data[0]),
    .m_valid (m_valid[0]),
    .m_ready (m_ready[0]),
    .m_data  (m_data[0]),
    .m_last  (m_last[0]),
    .busy    (busy[0])
  );

  bubble_sort_ctrl #(.DW(8), .NUM(8), .MODE(1)) dut_desc (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_valid (s_valid[1]),
    .s_ready (s_ready[1]),
    .s_data  (s_data[1]),
    .m_valid (m_valid[1]),
    .m_ready (m_ready[1]),
    .m_data  (m_data[1]),
    .m_last  (m_last[1]),
    .busy    (busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drives n elements starting at a negedge; returns at the negedge after the last handshake.
  task automatic load(input int u, input string tag, input vec_t din, input int n,
                      input bit gaps);
    for (int k = 0; k < n; k++) begin
      int gap;
      gap = gaps ? int'($urandom_range(0, 2)) : 0;
      for (int g = 0; g < gap; g++) begin
        s_valid[u] = 1'b0;
        s_data[u]  = 8'($urandom);
        @(negedge clk);
      end
      s_valid[u] = 1'b1;
      s_data[u]  = din[k];
      check($sformatf("%s_sready%0d", tag, k), s_ready[u], 1);
      @(negedge clk);
    end
    s_valid[u] = 1'b0;
    s_data[u]  = 8'($urandom);
  endtask

  task automatic run_batch(input int u, input string tag, input vec_t din, input vec_t exp,
                           input int exp_sort, input bit stress);
    int cyc;
    int sort_cyc;
    int idx;
    logic rdy;
    load(u, tag, din, 8, stress);
    cyc      = 0;
    sort_cyc = 0;
    while (!m_valid[u] && cyc < 100) begin
      if (s_ready[u]) check({tag, "_sort_sready"}, s_ready[u], 0);
      if (busy[u]) sort_cyc++;
      cyc++;
      @(negedge clk);
    end
    if (exp_sort >= 0) check({tag, "_sort_cycles"}, sort_cyc, exp_sort);
    idx = 0;
    cyc = 0;
    while (idx < 8 && cyc < 200) begin
      rdy = stress ? 1'($urandom_range(0, 1)) : 1'b1;
      m_ready[u] = rdy;
      if (m_valid[u]) begin
        check($sformatf("%s_data%0d", tag, idx), m_data[u], exp[idx]);
        check($sformatf("%s_last%0d", tag, idx), m_last[u], (idx == 7) ? 1 : 0);
        if (s_ready[u]) check({tag, "_drain_sready"}, s_ready[u], 0);
        if (rdy) idx++;
      end else begin
        check({tag, "_drain_mvalid"}, m_valid[u], 1);
      end
      cyc++;
      @(negedge clk);
    end
    m_ready[u] = 1'b0;
    check({tag, "_drain_count"}, idx, 8);
    check({tag, "_post_mvalid"}, m_valid[u], 0);
    check({tag, "_post_sready"}, s_ready[u], 1);
    check({tag, "_post_busy"}, busy[u], 0);
  endtask

  initial begin
    vec_t mix, mix_asc, mix_desc, ones, rev, dup, dup_asc, dup_desc;
    int   sort_mix, sort_sorted;
    mix      = '{8'h5A, 8'h03, 8'hFF, 8'h00, 8'h7E, 8'h7E, 8'h10, 8'hC1};
    mix_asc  = '{8'h00, 8'h03, 8'h10, 8'h5A, 8'h7E, 8'h7E, 8'hC1, 8'hFF};
    mix_desc = '{8'hFF, 8'hC1, 8'h7E, 8'h7E, 8'h5A, 8'h10, 8'h03, 8'h00};
    ones     = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    rev      = '{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    dup      = '{8'h33, 8'h33, 8'h01, 8'hFE, 8'h80, 8'h7F, 8'h02, 8'h33};
    dup_asc  = '{8'h01, 8'h02, 8'h33, 8'h33, 8'h33, 8'h7F, 8'h80, 8'hFE};
    dup_desc = '{8'hFE, 8'h80, 8'h7F, 8'h33, 8'h33, 8'h33, 8'h02, 8'h01};
`ifdef BUBBLE_SORT_CTRL_EARLY_EXIT_EN
    sort_mix    = -1;
    sort_sorted = 2;
`else
    sort_mix    = 8;
    sort_sorted = 8;
`endif

    rst_n   = 1'b0;
    s_valid = '0;
    m_ready = '0;
    s_data  = '{8'h00, 8'h00};
    #3;
    for (int u = 0; u < 2; u++) begin
      check($sformatf("rst_sready%0d", u), s_ready[u], 1);
      check($sformatf("rst_mvalid%0d", u), m_valid[u], 0);
      check($sformatf("rst_mlast%0d", u), m_last[u], 0);
      check($sformatf("rst_busy%0d", u), busy[u], 0);
      check($sformatf("rst_mdata%0d", u), m_data[u], 0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_batch(0, "asc_mix", mix, mix_asc, sort_mix, 1'b0);
    run_batch(1, "desc_mix", mix, mix_desc, sort_mix, 1'b0);
    run_batch(0, "asc_sorted", ones, ones, sort_sorted, 1'b0);
    run_batch(0, "asc_rev", rev, ones, 8, 1'b0);
    run_batch(1, "desc_rev", ones, rev, 8, 1'b0);
    run_batch(0, "asc_stress", dup, dup_asc, -1, 1'b1);
    run_batch(1, "desc_stress", dup, dup_desc, -1, 1'b1);

    // Reset after four loaded elements, checked before any clock edge.
    load(0, "part", rev, 4, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_sready", s_ready[0], 1);
    check("midrst_mvalid", m_valid[0], 0);
    check("midrst_busy", busy[0], 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_batch(0, "asc_after_rst", mix, mix_asc, sort_mix, 1'b0);

    // Reset in the middle of SORT must drop busy without a clock edge.
    load(1, "part_sort", mix, 8, 1'b0);
    repeat (3) @(negedge clk);
    check("sort_busy_pre", busy[1], 1);
    #1 rst_n = 1'b0;
    #1;
    check("sortrst_busy", busy[1], 0);
    check("sortrst_sready", s_ready[1], 1);
    check("sortrst_mvalid", m_valid[1], 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_batch(1, "desc_after_rst", dup, dup_desc, -1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
